// File: rtl/pulse_meas_if.sv
// pulse_meas_if: pulse input, enable and measurement results of pulse_meas
interface pulse_meas_if #(parameter int CNTR_WIDTH = 32);
  logic en, pulse_in, meas_valid, rise_strobe, stuck_high, stuck_low, busy;
  logic [CNTR_WIDTH-1:0] meas_high, meas_period;
  modport master(output en, pulse_in,
                 input meas_high, meas_period, meas_valid, rise_strobe, stuck_high, stuck_low, busy);
  modport slave(input en, pulse_in,
                output meas_high, meas_period, meas_valid, rise_strobe, stuck_high, stuck_low, busy);
endinterface

// File: rtl/pulse_meas.sv
// pulse_meas: measures high width and rise-to-rise period of a pulse train, flags stuck inputs
module pulse_meas #(
  parameter int CNTR_WIDTH  = 32,
  parameter int SYNC_STAGES = 0
) (
  input logic         clk,
  input logic         rst,
  pulse_meas_if.slave bus
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;
  localparam logic [CNTR_WIDTH-1:0] CMAX = '1;
  localparam logic [CNTR_WIDTH-1:0] ONE  = CNTR_WIDTH'(1);
  logic in_s, in_d_q, rise, fall, sat;
  state_e state_q, state_d;
  logic [CNTR_WIDTH-1:0] cntr_q, cntr_d, cap_q, cap_d, high_q, high_d, period_q, period_d;
  logic valid_q, valid_d, rise_q, rise_d, sh_q, sh_d, sl_q, sl_d, busy_q;
  if (SYNC_STAGES == 0) begin : g_nosync
    assign in_s = bus.pulse_in;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q;
    always_ff @(posedge clk or posedge rst)
      if (rst) sync_q <= '0;
      else sync_q <= SYNC_STAGES'({sync_q, bus.pulse_in});
    assign in_s = sync_q[SYNC_STAGES-1];
  end
  assign rise = in_s & ~in_d_q;
  assign fall = ~in_s & in_d_q;
  assign sat  = cntr_q == CMAX;
  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    high_d   = high_q;
    period_d = period_q;
    valid_d  = 1'b0;
    rise_d   = 1'b0;
    sh_d     = sh_q;
    sl_d     = sl_q;
    cntr_d   = rise ? ONE : sat ? cntr_q : cntr_q + ONE;
    // a real edge wins over saturation in the same cycle
    if (!bus.en) state_d = IDLE;
    else case (state_q)
      IDLE: if (rise) begin
        state_d = HIGH;
        rise_d  = 1'b1;
        sh_d    = 1'b0;
        sl_d    = 1'b0;
      end
      HIGH: if (fall) begin
        cap_d   = cntr_q;
        state_d = LOW;
      end else if (sat) begin
        sh_d    = 1'b1;
        state_d = IDLE;
      end
      LOW: if (rise) begin
        period_d = cntr_q;
        high_d   = cap_q;
        valid_d  = 1'b1;
        rise_d   = 1'b1;
        state_d  = HIGH;
      end else if (sat) begin
        sl_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= IDLE;
      in_d_q   <= 1'b0;
      cntr_q   <= '0;
      cap_q    <= '0;
      high_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      rise_q   <= 1'b0;
      sh_q     <= 1'b0;
      sl_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_d_q   <= in_s;
      cntr_q   <= cntr_d;
      cap_q    <= cap_d;
      high_q   <= high_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      rise_q   <= rise_d;
      sh_q     <= sh_d;
      sl_q     <= sl_d;
      busy_q   <= state_d != IDLE;
    end
  assign bus.meas_high   = high_q;
  assign bus.meas_period = period_q;
  assign bus.meas_valid  = valid_q;
  assign bus.rise_strobe = rise_q;
  assign bus.stuck_high  = sh_q;
  assign bus.stuck_low   = sl_q;
  assign bus.busy        = busy_q;
endmodule

// File: tb/tb_pulse_meas.sv
// tb_pulse_meas: two DUTs (0 and 2 sync stages) on shared stimulus, checked every cycle
// against a timestamp-based model of the measured waveform.
module tb_pulse_meas;
  localparam int W   = 8;
  localparam int MAX = 255;
  logic clk = 0, rst = 0, en = 1, pin = 0;
  int checks = 0, fails = 0, cyc = 0;
  int nv0 = 0, nv1 = 0, lr0 = 0, lr1 = 0, s0, s1;
  always #5 clk = ~clk;
  pulse_meas_if #(.CNTR_WIDTH(W)) b0();
  pulse_meas_if #(.CNTR_WIDTH(W)) b1();
  assign b0.en = en;
  assign b0.pulse_in = pin;
  assign b1.en = en;
  assign b1.pulse_in = pin;
  pulse_meas #(.CNTR_WIDTH(W), .SYNC_STAGES(0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
  pulse_meas #(.CNTR_WIDTH(W), .SYNC_STAGES(2)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  // ph: 0 not measuring, 1 inside high part, 2 inside low part; t_rise is the edge index of the last accepted rise
  typedef struct {
    int n, t_rise, ph, cap, high, period;
    logic [3:0] hist;
    logic prev, valid, rise, sh, sl, busy;
  } mdl_t;
  mdl_t m0, m1;
  function automatic mdl_t mzero();
    mdl_t z;
    z = '{default: 0};
    return z;
  endfunction
  function automatic mdl_t step(input mdl_t mi, input logic p, input logic e, input int s);
    mdl_t m;
    logic v, r, f;
    int el;
    m = mi;
    v = (s == 0) ? p : m.hist[s-1];
    m.hist = {m.hist[2:0], p};
    r = v & ~m.prev;
    f = ~v & m.prev;
    m.prev = v;
    el = m.n - m.t_rise;
    if (el > MAX) el = MAX;
    m.valid = 0;
    m.rise = 0;
    if (!e) m.ph = 0;
    else if (m.ph == 0) begin
      if (r) begin m.ph = 1; m.t_rise = m.n; m.rise = 1; m.sh = 0; m.sl = 0; end
    end else if (m.ph == 1) begin
      if (f) begin m.cap = el; m.ph = 2; end
      else if (el == MAX) begin m.sh = 1; m.ph = 0; end
    end else begin
      if (r) begin m.period = el; m.high = m.cap; m.valid = 1; m.rise = 1; m.t_rise = m.n; m.ph = 1; end
      else if (el == MAX) begin m.sl = 1; m.ph = 0; end
    end
    m.busy = m.ph != 0;
    m.n = m.n + 1;
    return m;
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) begin
      m0 <= mzero();
      m1 <= mzero();
    end else begin
      m0 <= step(m0, pin, en, 0);
      m1 <= step(m1, pin, en, 2);
    end
  task automatic cmp(input string nm, input mdl_t m, input logic [W-1:0] h, p,
                     input logic v, r, sh, sl, b);
    logic [W-1:0] eh, ep;
    eh = W'(m.high);
    ep = W'(m.period);
    checks++;
    if ({h, p, v, r, sh, sl, b} !== {eh, ep, m.valid, m.rise, m.sh, m.sl, m.busy}) begin
      fails++;
      $display("FAIL %s cyc %0d: got h=%0d p=%0d v=%b r=%b sh=%b sl=%b busy=%b want h=%0d p=%0d v=%b r=%b sh=%b sl=%b busy=%b",
               nm, cyc, h, p, v, r, sh, sl, b, eh, ep, m.valid, m.rise, m.sh, m.sl, m.busy);
    end
  endtask
  task automatic lit(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    cmp("sync0", m0, b0.meas_high, b0.meas_period, b0.meas_valid, b0.rise_strobe, b0.stuck_high, b0.stuck_low, b0.busy);
    cmp("sync2", m1, b1.meas_high, b1.meas_period, b1.meas_valid, b1.rise_strobe, b1.stuck_high, b1.stuck_low, b1.busy);
    if (b0.meas_valid) nv0++;
    if (b1.meas_valid) nv1++;
    if (b0.rise_strobe) lr0 = cyc;
    if (b1.rise_strobe) lr1 = cyc;
  end
  task automatic drive(input logic v, input int n);
    repeat (n) begin
      pin = v;
      @(negedge clk);
    end
  endtask
  initial begin
    int hl, ll;
    #1 rst = 1;
    #12;
    lit("rst_out0", int'({b0.meas_high, b0.meas_period, b0.meas_valid, b0.rise_strobe, b0.stuck_high, b0.stuck_low, b0.busy}), 0);
    @(negedge clk);
    rst = 0;
    drive(0, 4);
    // 3 high / 7 low
    s0 = nv0; s1 = nv1;
    repeat (6) begin drive(1, 3); drive(0, 7); end
    lit("a_cnt0", nv0 - s0, 5);
    lit("a_cnt2", nv1 - s1, 5);
    lit("a_high0", b0.meas_high, 3);
    lit("a_per0", b0.meas_period, 10);
    lit("a_high2", b1.meas_high, 3);
    lit("a_per2", b1.meas_period, 10);
    lit("a_mdl_high", m0.high, 3);
    lit("a_mdl_per", m1.period, 10);
    // 1/0 toggling
    s0 = nv0; s1 = nv1;
    repeat (10) begin drive(1, 1); drive(0, 1); end
    drive(0, 3);
    lit("b_cnt0", nv0 - s0, 10);
    lit("b_cnt2", nv1 - s1, 10);
    lit("b_high0", b0.meas_high, 1);
    lit("b_per0", b0.meas_period, 2);
    lit("b_per2", b1.meas_period, 2);
    // stuck high, then recovery
    drive(1, 5);
    s0 = nv0;
    drive(1, 295);
    lit("c_noval", nv0 - s0, 0);
    lit("c_sh0", b0.stuck_high, 1);
    lit("c_busy0", b0.busy, 0);
    lit("c_sh2", b1.stuck_high, 1);
    lit("c_busy2", b1.busy, 0);
    drive(0, 3);
    drive(1, 4);
    lit("c_shclr0", b0.stuck_high, 0);
    lit("c_shclr2", b1.stuck_high, 0);
    drive(0, 6);
    drive(1, 1);
    drive(0, 3);
    lit("c_high0", b0.meas_high, 4);
    lit("c_per0", b0.meas_period, 10);
    lit("c_per2", b1.meas_period, 10);
    // longest measurable period, then stuck low
    drive(1, 5);
    drive(0, 250);
    drive(1, 5);
    lit("d_per0", b0.meas_period, 255);
    lit("d_high0", b0.meas_high, 5);
    lit("d_sl0", b0.stuck_low, 0);
    lit("d_per2", b1.meas_period, 255);
    drive(0, 400);
    lit("d_slset0", b0.stuck_low, 1);
    lit("d_slset2", b1.stuck_low, 1);
    lit("d_busy0", b0.busy, 0);
    lit("d_hold_per", b0.meas_period, 255);
    lit("d_hold_high", b0.meas_high, 5);
    // asynchronous reset in the middle of a high phase
    drive(1, 3);
    #2 rst = 1;
    #1;
    lit("e_rst0", int'({b0.meas_high, b0.meas_period, b0.meas_valid, b0.rise_strobe, b0.stuck_high, b0.stuck_low, b0.busy}), 0);
    lit("e_rst2", int'({b1.meas_high, b1.meas_period, b1.meas_valid, b1.rise_strobe, b1.stuck_high, b1.stuck_low, b1.busy}), 0);
    @(negedge clk);
    rst = 0;
    s0 = nv0; s1 = nv1;
    drive(1, 2); drive(0, 4); drive(1, 2); drive(0, 4); drive(1, 1); drive(0, 4);
    lit("e_cnt0", nv0 - s0, 2);
    lit("e_cnt2", nv1 - s1, 2);
    lit("e_high0", b0.meas_high, 2);
    lit("e_per0", b0.meas_period, 6);
    // enable dropped in the low phase
    drive(1, 3);
    drive(0, 2);
    en = 0;
    drive(0, 4);
    en = 1;
    s0 = nv0; s1 = nv1;
    drive(0, 2); drive(1, 3); drive(0, 7); drive(1, 3); drive(0, 7);
    lit("f_cnt0", nv0 - s0, 1);
    lit("f_cnt2", nv1 - s1, 1);
    lit("f_high2", b1.meas_high, 3);
    lit("f_per2", b1.meas_period, 10);
    lit("f_lat", lr1 - lr0, 2);
    // random segments, occasional long ones and enable glitches
    repeat (150) begin
      hl = ($urandom_range(0, 15) == 0) ? $urandom_range(240, 270) : $urandom_range(1, 10);
      ll = ($urandom_range(0, 15) == 0) ? $urandom_range(240, 270) : $urandom_range(1, 10);
      en = $urandom_range(0, 19) != 0;
      drive(1, hl);
      en = 1;
      drive(0, ll);
    end
    drive(0, 2);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/pulse_meas.md
Name: pulse_meas

Overview:
- Measures a periodic digital pulse train: high width and period of each cycle, in clk cycles.
- It is the receiving end of the team's pulse generator. A generator programmed with cntr_max/cntr_low should be reported as period = cntr_max+1 and high = cntr_max-cntr_low+1.
- Used for loopback self-test of generated PWM/strobes and for measuring externally supplied pulse signals.
- Also flags stuck-high and stuck-low inputs.

Parameters:
- CNTR_WIDTH, 32, width of the counters and measurement outputs; maximum measurable value is 2^CNTR_WIDTH-1.
- SYNC_STAGES, 0, number of input synchronizer flops on pulse_in. 0 means pulse_in is already synchronous to clk; 2 or more for asynchronous sources. The value 1 is not allowed.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  measurement enable; low forces IDLE
- pulse_in  in  1  measured signal
- meas_high  out  CNTR_WIDTH  high width of the last complete period
- meas_period  out  CNTR_WIDTH  rising-edge-to-rising-edge period of the last complete period
- meas_valid  out  1  one-cycle strobe; meas_high and meas_period were updated this cycle
- rise_strobe  out  1  one-cycle strobe on every accepted rising edge
- stuck_high  out  1  sticky; input stayed high for 2^CNTR_WIDTH-1 cycles
- stuck_low  out  1  sticky; input stayed low until the period counter saturated
- busy  out  1  state is not IDLE

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. All outputs are registered. Every register resets to 0 and state resets to IDLE, immediately on rst assertion (also mid-operation).
- Input path:
  - in_s is pulse_in delayed by SYNC_STAGES flops (combinational pass-through when 0).
  - in_d <= in_s each cycle.
  - rise = in_s & ~in_d; fall = ~in_s & in_d.
  - in_d resets to 0, so an input that is already high at reset release counts as a rise.
- Latency: with SYNC_STAGES=0, the clk edge E that first samples pulse_in high performs the FSM action. rise_strobe and meas_valid are high in the cycle after E. Each synchronizer stage adds 1 cycle.
- Counter: a single period_cntr of width CNTR_WIDTH.
  - Loaded with 1 on rise.
  - Otherwise incremented, saturating at 2^CNTR_WIDTH-1.
- FSM states:
  - IDLE:
    - On rise & en: period_cntr <= 1, rise_strobe <= 1, stuck_high <= 0, stuck_low <= 0, go to HIGH.
    - No meas_valid is emitted, because no preceding period exists.
  - HIGH:
    - On fall: high_cap <= period_cntr, go to LOW.
    - Else, if period_cntr == max: stuck_high <= 1, go to IDLE.
  - LOW:
    - On rise: meas_period <= period_cntr, meas_high <= high_cap, meas_valid <= 1, rise_strobe <= 1, period_cntr <= 1, go to HIGH.
    - Else, if period_cntr == max: stuck_low <= 1, go to IDLE.
- Simultaneous events:
  - In LOW, rise wins over saturation, so a period of exactly 2^CNTR_WIDTH-1 is valid.
  - In HIGH, fall wins over saturation.
  - Maximum measurable period is 2^CNTR_WIDTH-1. Maximum high width is 2^CNTR_WIDTH-2.
- Minimum measurable pattern: high 1, low 1, giving high=1, period=2.
- Enable:
  - en low in any state: go to IDLE next cycle and emit no strobes.
  - meas_high, meas_period and the stuck flags hold their values.
  - Re-enabling requires a fresh rise; the first period after re-enable is not reported.
- Output holding:
  - meas_valid and rise_strobe are one cycle wide.
  - meas_high and meas_period hold until the next meas_valid.
  - stuck_* flags hold until the next accepted rise in IDLE, or reset.
- busy = (state != IDLE), registered alongside state.

Test Plan:
- CNTR_WIDTH=8, SYNC_STAGES=0, en=1:
  - Stimulus: repeating 3 cycles high / 7 low (generator cntr_max=9, cntr_low=7).
  - Required: no meas_valid on the first rise; from the second rise on, meas_valid every 10 cycles with meas_high=3, meas_period=10; rise_strobe on every rise.
- Stimulus: alternating 1/0 every cycle.
  - Required: meas_high=1, meas_period=2, meas_valid every 2 cycles after the second rise.
- Stimulus: one rise, then pulse_in held high.
  - Required: stuck_high=1 and busy=0 on the cycle after period_cntr reaches 255, with no meas_valid.
  - Then a low followed by a rise: stuck_high clears on the rise; the next full period is reported correctly.
- Stimulus: 5 high then 250 low (period 255).
  - Required: meas_valid with meas_high=5, meas_period=255, no stuck_low.
  - Then 5 high and a permanent low: stuck_low=1, FSM in IDLE, meas values still 5/255.
- Stimulus: assert rst for 1 cycle mid-HIGH.
  - Required: all outputs 0 immediately, without waiting for a clk edge.
  - After release: first rise gives rise_strobe only; second rise gives the first meas_valid.
- Stimulus: en dropped mid-LOW for 4 cycles, then restored, with SYNC_STAGES=2.
  - Required: no meas_valid for the interrupted period; measurements resume from the second rise after re-enable; latency is 3 cycles from the sampling edge.
